// File: rtl/video_timing_gen.sv
// video_timing_gen: raster timing generator (hsync/vsync/de plus pixel coordinates).
// Latency: every output is registered and reflects the counter values of the previous clk.
// Flow control: none; en=0 parks the raster at the origin with all outputs idle, and en=1 restarts it from the origin.
// Ports:
//   clk          pixel clock
//   reset        asynchronous, active-high reset
//   en           run enable, synchronous to clk
//   hsync/vsync  sync outputs, active level set by HS_POL / VS_POL
//   de           data enable, high during active pixels
//   x, y         registered horizontal/vertical counter values
//   line_start   one-cycle pulse at x=0
//   frame_start  one-cycle pulse at x=0, y=0
module video_timing_gen #(
  parameter int H_ACTIVE = 1280,
  parameter int H_FP     = 110,
  parameter int H_SYNC   = 40,
  parameter int H_BP     = 220,
  parameter int V_ACTIVE = 720,
  parameter int V_FP     = 5,
  parameter int V_SYNC   = 5,
  parameter int V_BP     = 20,
  parameter bit HS_POL   = 1'b1,
  parameter bit VS_POL   = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  output logic        hsync,
  output logic        vsync,
  output logic        de,
  output logic [11:0] x,
  output logic [10:0] y,
  output logic        line_start,
  output logic        frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  if (H_TOTAL > 4096 || V_TOTAL > 2048) begin : g_size_check
    $error("video_timing_gen: H_TOTAL must be <= 4096 and V_TOTAL <= 2048");
  end

  // Comparisons are done one bit wider than the counters so that boundary
  // constants equal to 4096 / 2048 stay representable.
  localparam logic [12:0] H_ACT_END = 13'(H_ACTIVE);
  localparam logic [12:0] HS_BEG    = 13'(H_ACTIVE + H_FP);
  localparam logic [12:0] HS_END    = 13'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [12:0] H_LAST    = 13'(H_TOTAL - 1);
  localparam logic [11:0] V_ACT_END = 12'(V_ACTIVE);
  localparam logic [11:0] VS_BEG    = 12'(V_ACTIVE + V_FP);
  localparam logic [11:0] VS_END    = 12'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [11:0] V_LAST    = 12'(V_TOTAL - 1);

  logic [11:0] h_cnt;
  logic [10:0] v_cnt;
  logic [12:0] hx;
  logic [11:0] vx;
  logic        h_act;
  logic        v_act;
  logic        hs_act;
  logic        vs_act;

  assign hx     = {1'b0, h_cnt};
  assign vx     = {1'b0, v_cnt};
  assign h_act  = (hx < H_ACT_END);
  assign v_act  = (vx < V_ACT_END);
  assign hs_act = (hx >= HS_BEG) && (hx < HS_END);
  assign vs_act = (vx >= VS_BEG) && (vx < VS_END);

  // Raster counters. Dropping en always returns to the origin, so a partial
  // frame is never resumed.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (!en) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (hx == H_LAST) begin
      h_cnt <= '0;
      v_cnt <= (vx == V_LAST) ? '0 : v_cnt + 11'd1;
    end else begin
      h_cnt <= h_cnt + 12'd1;
    end
  end

  // Output stage: decoded from the current counters, so all outputs trail
  // the counters by exactly one clock and stay aligned with x/y.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hsync       <= ~HS_POL;
      vsync       <= ~VS_POL;
      de          <= 1'b0;
      x           <= '0;
      y           <= '0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else if (!en) begin
      hsync       <= ~HS_POL;
      vsync       <= ~VS_POL;
      de          <= 1'b0;
      x           <= '0;
      y           <= '0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      hsync       <= hs_act ? HS_POL : ~HS_POL;
      vsync       <= vs_act ? VS_POL : ~VS_POL;
      de          <= h_act && v_act;
      x           <= h_cnt;
      y           <= v_cnt;
      line_start  <= (h_cnt == 12'd0);
      frame_start <= (h_cnt == 12'd0) && (v_cnt == 11'd0);
    end
  end

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen: one default-timing instance and one small,
// negative-polarity instance, both compared every cycle against a
// time-index model, plus hand-computed expectations.
module tb_video_timing_gen;

  typedef struct packed {
    logic        hs;
    logic        vs;
    logic        de;
    logic        ls;
    logic        fs;
    logic [11:0] x;
    logic [10:0] y;
  } out_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic en = 1'b0;

  logic hs0, vs0, de0, ls0, fs0;
  logic [11:0] x0;
  logic [10:0] y0;
  logic hs1, vs1, de1, ls1, fs1;
  logic [11:0] x1;
  logic [10:0] y1;

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  video_timing_gen dut0 (
    .clk(clk), .reset(reset), .en(en),
    .hsync(hs0), .vsync(vs0), .de(de0), .x(x0), .y(y0),
    .line_start(ls0), .frame_start(fs0)
  );

  // Small raster: H_TOTAL=17, V_TOTAL=10, frame = 170 cycles.
  video_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(4),
    .V_ACTIVE(5), .V_FP(1), .V_SYNC(2), .V_BP(2),
    .HS_POL(1'b0), .VS_POL(1'b0)
  ) dut1 (
    .clk(clk), .reset(reset), .en(en),
    .hsync(hs1), .vsync(vs1), .de(de1), .x(x1), .y(y1),
    .line_start(ls1), .frame_start(fs1)
  );

  out_t got0, got1, exp0, exp1;
  assign got0 = {hs0, vs0, de0, ls0, fs0, x0, y0};
  assign got1 = {hs1, vs1, de1, ls1, fs1, x1, y1};

  // Model: t counts enabled cycles since the last clear; the raster position
  // is derived arithmetically from t.
  function automatic out_t model_out(int t, int ha, int hf, int hw, int hb,
                                     int va, int vf, int vw, int vb, bit hp, bit vp);
    int ht, vt, h, v;
    out_t o;
    ht = ha + hf + hw + hb;
    vt = va + vf + vw + vb;
    h = t % ht;
    v = (t / ht) % vt;
    o.x = 12'(h);
    o.y = 11'(v);
    o.de = (h < ha) && (v < va);
    o.hs = (h >= ha + hf && h < ha + hf + hw) ? hp : !hp;
    o.vs = (v >= va + vf && v < va + vf + vw) ? vp : !vp;
    o.ls = (h == 0);
    o.fs = (h == 0) && (v == 0);
    return o;
  endfunction

  function automatic out_t idle_out(bit hp, bit vp);
    out_t o;
    o = '0;
    o.hs = !hp;
    o.vs = !vp;
    return o;
  endfunction

  int t = 0;
  always @(posedge clk or posedge reset) begin
    if (reset || !en) begin
      t = 0;
      exp0 = idle_out(1'b1, 1'b1);
      exp1 = idle_out(1'b0, 1'b0);
    end else begin
      exp0 = model_out(t, 1280, 110, 40, 220, 720, 5, 5, 20, 1'b1, 1'b1);
      exp1 = model_out(t, 8, 2, 3, 4, 5, 1, 2, 2, 1'b0, 1'b0);
      t = t + 1;
    end
  end

  task automatic cmp(string name, out_t got, out_t want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s at %0t: got=%h want=%h", name, $time, got, want);
    end
  endtask

  task automatic chk(string name, int got, int want);
    checks++;
    if (got != want) begin
      failures++;
      $display("FAIL %s: got=%0d want=%0d", name, got, want);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      cmp("model_dut0", got0, exp0);
      cmp("model_dut1", got1, exp1);
    end
  end

  initial begin
    int de_fall, de_rise2, hs_rise, hs_fall;
    int fs_first, fs_second, vs_cnt, vs_first, de1_cnt, wrap_seen, n;
    bit wrap_pend;
    de_fall = -1; de_rise2 = -1; hs_rise = -1; hs_fall = -1;
    fs_first = -1; fs_second = -1; vs_cnt = 0; vs_first = -1;
    de1_cnt = 0; wrap_seen = 0; wrap_pend = 1'b0;

    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    chk("reset_hs1_inactive", hs1, 1);
    chk("reset_hs0_inactive", hs0, 0);
    chk("reset_x0", x0, 0);

    @(negedge clk);
    reset = 1'b0;
    en = 1'b1;

    // k indexes negedges after release; k=0 shows the first enabled edge.
    for (int k = 0; k < 3400; k++) begin
      @(negedge clk);
      if (k == 0) begin
        chk("first_fs0", fs0, 1);
        chk("first_fs1", fs1, 1);
        chk("first_ls1", ls1, 1);
        chk("first_de0", de0, 1);
      end
      if (de_fall < 0 && !de0) de_fall = k;
      else if (de_fall >= 0 && de_rise2 < 0 && de0) de_rise2 = k;
      if (hs_rise < 0 && hs0) hs_rise = k;
      else if (hs_rise >= 0 && hs_fall < 0 && !hs0) hs_fall = k;
      if (fs1) begin
        if (fs_first < 0) fs_first = k;
        else if (fs_second < 0) fs_second = k;
      end
      if (k < 170) begin
        if (!vs1) begin
          vs_cnt++;
          if (vs_first < 0) begin
            vs_first = k;
            chk("vs_start_x", x1, 0);
            chk("vs_start_y", y1, 6);
          end
        end
        if (de1) de1_cnt++;
      end
      if (wrap_pend) begin
        chk("wrap_x", x1, 0);
        chk("wrap_y", y1, 0);
        chk("wrap_fs", fs1, 1);
        chk("wrap_ls", ls1, 1);
        wrap_pend = 1'b0;
        wrap_seen++;
      end
      if (x1 == 12'd16 && y1 == 11'd9) wrap_pend = 1'b1;
    end

    chk("de0_high_len", de_fall, 1280);
    chk("de0_low_len", de_rise2 - de_fall, 370);
    chk("hs0_after_de", hs_rise - de_fall, 110);
    chk("hs0_width", hs_fall - hs_rise, 40);
    chk("fs1_first", fs_first, 0);
    chk("fs1_period", fs_second - fs_first, 170);
    chk("vs1_frame_cycles", vs_cnt, 34);
    chk("vs1_first", vs_first, 102);
    chk("de1_frame_cycles", de1_cnt, 40);
    chk("wrap_count", wrap_seen, 19);

    // en dropped for 3 cycles mid-frame.
    n = 0;
    while (!(x1 == 12'd5 && y1 == 11'd3) && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("drop_point_found", int'(n < 400), 1);
    en = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("drop_de1", de1, 0);
      chk("drop_hs1", hs1, 1);
      chk("drop_vs1", vs1, 1);
      chk("drop_de0", de0, 0);
      chk("drop_hs0", hs0, 0);
      chk("drop_vs0", vs0, 0);
    end
    en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("resume_x1", x1, i);
      chk("resume_y1", y1, 0);
      chk("resume_x0", x0, i);
    end

    // Asynchronous reset while dut1 is inside its (active-low) hsync.
    n = 0;
    while (hs1 !== 1'b0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("hs1_active_found", int'(n < 100), 1);
    #2;
    reset = 1'b1;
    #1;
    chk("async_hs1", hs1, 1);
    chk("async_vs1", vs1, 1);
    chk("async_x1", x1, 0);
    chk("async_de0", de0, 0);
    chk("async_hs0", hs0, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("restart_fs1", fs1, 1);
    chk("restart_x1", x1, 0);
    repeat (40) @(negedge clk);

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
